// File: rtl/cpu_wb_arbiter.sv
// cpu_wb_arbiter: writeback scheduler for long-latency CPU results.
// Load returns from the dcache and divider results are buffered in
// per-source circular queues. Load data is formatted on entry with
// byte/half/word extraction and sign extension. A single registered output
// slot drives the CPU writeback port, granted round-robin between sources.
// A per-register pending scoreboard (reg_busy) tracks outstanding results.
//
// Optional feature macro: WB_ARB_ERR_CHECK_EN
//   defined   -> sticky error_flags with a $display on each first assertion
//   undefined -> error_flags tied to zero, no check logic is built
module cpu_wb_arbiter #(
  parameter int Q_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_dcache_rvalid,
  output logic        cpu_dcache_rready,
  input  logic [31:0] cpu_dcache_rdata,
  input  logic [8:0]  cpu_dcache_rtag,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [31:0] div_result,
  input  logic [4:0]  div_dest_reg,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  output logic [31:0] reg_busy,
  output logic        wb_valid,
  output logic [4:0]  wb_dest_reg,
  output logic [31:0] wb_data,
  input  logic        cpu_ready,
  output logic [2:0]  error_flags
);

  localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(Q_DEPTH);

  typedef enum logic {
    SRC_DC  = 1'b0,
    SRC_DIV = 1'b1
  } src_e;

  // Extract and sign-extend the addressed byte/half of a load return.
  // Unknown size/offset codes produce zero.
  function automatic logic [31:0] fmt_load(input logic [3:0]  code,
                                           input logic [31:0] raw);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    case (code[1:0])
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = code[1] ? raw[31:16] : raw[15:0];
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: w = b;
      4'b0100, 4'b0110:                   w = h;
      4'b1000:                            w = raw;
      default:                            w = '0;
    endcase
    return w;
  endfunction

  // Size/offset codes that do not map to a legal extraction.
  function automatic logic bad_code(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0110, 4'b1000: return 1'b0;
      default:                   return 1'b1;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Input stage: source handshakes and load formatting
  // ---------------------------------------------------------------------
  logic [31:0]   dc_data_q [Q_DEPTH];
  logic [4:0]    dc_reg_q  [Q_DEPTH];
  logic [PW-1:0] dc_wp_q, dc_rp_q;
  logic [CW-1:0] dc_cnt_q;

  logic [31:0]   dv_data_q [Q_DEPTH];
  logic [4:0]    dv_reg_q  [Q_DEPTH];
  logic [PW-1:0] dv_wp_q, dv_rp_q;
  logic [CW-1:0] dv_cnt_q;

  logic [31:0] dc_fmt;
  logic        dc_xfer, dc_push, dc_pop, dc_nempty;
  logic        dv_xfer, dv_push, dv_pop, dv_nempty;

  // Readiness depends only on registered occupancy, never on valid.
  assign cpu_dcache_rready = (dc_cnt_q != FULL_CNT);
  assign div_ready         = (dv_cnt_q != FULL_CNT);

  assign dc_fmt  = fmt_load(cpu_dcache_rtag[8:5], cpu_dcache_rdata);
  assign dc_xfer = cpu_dcache_rvalid && cpu_dcache_rready;
  assign dv_xfer = div_valid && div_ready;
  // Beats targeting r0 complete the handshake but are never queued.
  assign dc_push = dc_xfer && (cpu_dcache_rtag[4:0] != 5'd0);
  assign dv_push = dv_xfer && (div_dest_reg != 5'd0);

  assign dc_nempty = (dc_cnt_q != '0);
  assign dv_nempty = (dv_cnt_q != '0);

  // ---------------------------------------------------------------------
  // Queue stage: per-source circular buffers
  // ---------------------------------------------------------------------
  // Dcache queue pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      dc_wp_q  <= '0;
      dc_rp_q  <= '0;
      dc_cnt_q <= '0;
    end else begin
      if (dc_push) dc_wp_q <= dc_wp_q + PW'(1);
      if (dc_pop)  dc_rp_q <= dc_rp_q + PW'(1);
      dc_cnt_q <= dc_cnt_q + CW'(dc_push) - CW'(dc_pop);
    end
  end

  // Dcache queue payload; contents are only meaningful below the count.
  always_ff @(posedge clock) begin
    if (dc_push) begin
      dc_data_q[dc_wp_q] <= dc_fmt;
      dc_reg_q[dc_wp_q]  <= cpu_dcache_rtag[4:0];
    end
  end

  // Divider queue pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      dv_wp_q  <= '0;
      dv_rp_q  <= '0;
      dv_cnt_q <= '0;
    end else begin
      if (dv_push) dv_wp_q <= dv_wp_q + PW'(1);
      if (dv_pop)  dv_rp_q <= dv_rp_q + PW'(1);
      dv_cnt_q <= dv_cnt_q + CW'(dv_push) - CW'(dv_pop);
    end
  end

  // Divider queue payload.
  always_ff @(posedge clock) begin
    if (dv_push) begin
      dv_data_q[dv_wp_q] <= div_result;
      dv_reg_q[dv_wp_q]  <= div_dest_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Arbitration: round-robin between queue heads
  // ---------------------------------------------------------------------
  logic wb_valid_q;
  logic [4:0]  wb_dest_q;
  logic [31:0] wb_data_q;
  logic slot_free;
  logic gnt_dc, gnt_dv;
  src_e rr_q, rr_d;

  assign slot_free = !wb_valid_q || cpu_ready;
  assign dc_pop    = gnt_dc;
  assign dv_pop    = gnt_dv;

  // Grant selection; rr_last only moves when both heads compete.
  always_comb begin
    rr_d   = rr_q;
    gnt_dc = 1'b0;
    gnt_dv = 1'b0;
    if (slot_free) begin
      if (dc_nempty && dv_nempty) begin
        if (rr_q == SRC_DIV) begin
          gnt_dc = 1'b1;
          rr_d   = SRC_DC;
        end else begin
          gnt_dv = 1'b1;
          rr_d   = SRC_DIV;
        end
      end else if (dc_nempty) begin
        gnt_dc = 1'b1;
      end else if (dv_nempty) begin
        gnt_dv = 1'b1;
      end
    end
  end

  // Round-robin state; starts at DIV so the dcache wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) rr_q <= SRC_DIV;
    else       rr_q <= rr_d;
  end

  // ---------------------------------------------------------------------
  // Output stage: single registered writeback slot
  // ---------------------------------------------------------------------
  // Load the granted head when the slot frees up; otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
    end else if (slot_free) begin
      if (gnt_dc) begin
        wb_valid_q <= 1'b1;
        wb_dest_q  <= dc_reg_q[dc_rp_q];
        wb_data_q  <= dc_data_q[dc_rp_q];
      end else if (gnt_dv) begin
        wb_valid_q <= 1'b1;
        wb_dest_q  <= dv_reg_q[dv_rp_q];
        wb_data_q  <= dv_data_q[dv_rp_q];
      end else begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_dest_reg = wb_dest_q;
  assign wb_data     = wb_data_q;

  // ---------------------------------------------------------------------
  // Pending-register scoreboard
  // ---------------------------------------------------------------------
  logic [31:0] busy_q, busy_d;
  logic        wb_consume;

  assign wb_consume = wb_valid_q && cpu_ready;

  // Clear on consumed writeback, then set on issue so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_consume) busy_d[wb_dest_q] = 1'b0;
    if (issue_valid && (issue_reg != 5'd0)) busy_d[issue_reg] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clock) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign reg_busy = busy_q;

`ifdef WB_ARB_ERR_CHECK_EN
  // ---------------------------------------------------------------------
  // Sticky protocol checks
  // ---------------------------------------------------------------------
  logic [2:0] err_q, err_d;
  logic       clr_same;

  // An issue that lands on the register being retired this cycle is a
  // legitimate reuse, not a duplicate.
  assign clr_same = wb_consume && (wb_dest_q == issue_reg);

  // Accumulate error causes onto the sticky flags.
  always_comb begin
    err_d = err_q;
    if ((dc_xfer && bad_code(cpu_dcache_rtag[8:5])) ||
        (dc_push && (dc_cnt_q == FULL_CNT)) ||
        (dv_push && (dv_cnt_q == FULL_CNT)))
      err_d[0] = 1'b1;
    if (issue_valid && (issue_reg != 5'd0) && busy_q[issue_reg] && !clr_same)
      err_d[1] = 1'b1;
    if (wb_consume && !busy_q[wb_dest_q])
      err_d[2] = 1'b1;
  end

  // Flag register with a message on each first assertion.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
      if (err_d[0] && !err_q[0])
        $display("ERROR %t: cpu_wb_arbiter bad rtag code or queue overflow", $time);
      if (err_d[1] && !err_q[1])
        $display("ERROR %t: cpu_wb_arbiter duplicate issue to pending reg %0d", $time, issue_reg);
      if (err_d[2] && !err_q[2])
        $display("ERROR %t: cpu_wb_arbiter writeback to non-pending reg %0d", $time, wb_dest_q);
    end
  end

  assign error_flags = err_q;
`else
  assign error_flags = '0;
`endif

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Self-checking bench for cpu_wb_arbiter: table-driven single-beat formatting
// vectors plus hand-written sequences for latency, round-robin ties,
// backpressure, scoreboard set/clear and mid-operation reset. Writeback beats
// are checked against a queue of expected results.
module tb_cpu_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_dcache_rvalid;
  logic        cpu_dcache_rready;
  logic [31:0] cpu_dcache_rdata;
  logic [8:0]  cpu_dcache_rtag;
  logic        div_valid;
  logic        div_ready;
  logic [31:0] div_result;
  logic [4:0]  div_dest_reg;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [31:0] reg_busy;
  logic        wb_valid;
  logic [4:0]  wb_dest_reg;
  logic [31:0] wb_data;
  logic        cpu_ready;
  logic [2:0]  error_flags;

  always #5 clock = ~clock;

  cpu_wb_arbiter #(.Q_DEPTH(2)) dut (
    .clock             (clock),
    .reset             (reset),
    .cpu_dcache_rvalid (cpu_dcache_rvalid),
    .cpu_dcache_rready (cpu_dcache_rready),
    .cpu_dcache_rdata  (cpu_dcache_rdata),
    .cpu_dcache_rtag   (cpu_dcache_rtag),
    .div_valid         (div_valid),
    .div_ready         (div_ready),
    .div_result        (div_result),
    .div_dest_reg      (div_dest_reg),
    .issue_valid       (issue_valid),
    .issue_reg         (issue_reg),
    .reg_busy          (reg_busy),
    .wb_valid          (wb_valid),
    .wb_dest_reg       (wb_dest_reg),
    .wb_data           (wb_data),
    .cpu_ready         (cpu_ready),
    .error_flags       (error_flags)
  );

`ifdef WB_ARB_ERR_CHECK_EN
  localparam logic [2:0] ERR_AFTER_TABLE = 3'b001;
  localparam logic [2:0] ERR_AFTER_DUP   = 3'b011;
`else
  localparam logic [2:0] ERR_AFTER_TABLE = 3'b000;
  localparam logic [2:0] ERR_AFTER_DUP   = 3'b000;
`endif

  typedef struct {
    logic        src;   // 0 = dcache, 1 = divider
    logic [3:0]  code;
    logic [31:0] data;
    logic [4:0]  rg;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  rg;
    logic [31:0] data;
  } exp_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];
  exp_t sb [$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // Compare each consumed writeback against the oldest expected result.
  task automatic monitor();
    exp_t e;
    if (wb_valid && cpu_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL wb_unexpected: actual reg %0d data %h required no beat", wb_dest_reg, wb_data);
      end else begin
        e = sb.pop_front();
        check("wb_reg", 32'(wb_dest_reg), 32'(e.rg));
        check("wb_data", wb_data, e.data);
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] r);
    issue_valid = 1'b1;
    issue_reg   = r;
    tick();
    issue_valid = 1'b0;
    issue_reg   = 5'd0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'b0000, 32'h1234_5681, 5'd5,  32'hFFFF_FF81};
    vecs[1]  = '{1'b0, 4'b0001, 32'h0000_7F00, 5'd6,  32'h0000_007F};
    vecs[2]  = '{1'b0, 4'b0010, 32'h00AB_0000, 5'd8,  32'hFFFF_FFAB};
    vecs[3]  = '{1'b0, 4'b0100, 32'h0001_8000, 5'd10, 32'hFFFF_8000};
    vecs[4]  = '{1'b0, 4'b0110, 32'h7FFF_1234, 5'd11, 32'h0000_7FFF};
    vecs[5]  = '{1'b0, 4'b0110, 32'h8000_1234, 5'd12, 32'hFFFF_8000};
    vecs[6]  = '{1'b0, 4'b1000, 32'hDEAD_BEEF, 5'd13, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 4'b0101, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000};
    vecs[8]  = '{1'b1, 4'b0000, 32'h8765_4321, 5'd15, 32'h8765_4321};
    vecs[9]  = '{1'b0, 4'b0100, 32'h0000_7FFF, 5'd16, 32'h0000_7FFF};
    vecs[10] = '{1'b0, 4'b1111, 32'h1234_5678, 5'd17, 32'h0000_0000};

    reset = 1'b1;
    cpu_dcache_rvalid = 1'b0; cpu_dcache_rdata = '0; cpu_dcache_rtag = '0;
    div_valid = 1'b0; div_result = '0; div_dest_reg = '0;
    issue_valid = 1'b0; issue_reg = '0; cpu_ready = 1'b1;
    repeat (2) tick();
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_dest", 32'(wb_dest_reg), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_busy", reg_busy, 32'd0);
    check("rst_err", 32'(error_flags), 32'd0);
    check("rst_rready", 32'(cpu_dcache_rready), 32'd1);
    check("rst_div_ready", 32'(div_ready), 32'd1);
    reset = 1'b0;
    tick();

    // Latency and byte-3 sign extension.
    issue(5'd7);
    check("busy7_set", 32'(reg_busy[7]), 32'd1);
    cpu_dcache_rvalid = 1'b1; cpu_dcache_rtag = {4'b0011, 5'd7}; cpu_dcache_rdata = 32'h80FF_0000;
    sb.push_back('{5'd7, 32'hFFFF_FF80});
    tick();
    cpu_dcache_rvalid = 1'b0;
    check("lat_t1_valid", 32'(wb_valid), 32'd0);
    tick();
    check("lat_t2_valid", 32'(wb_valid), 32'd1);
    check("lat_t2_reg", 32'(wb_dest_reg), 32'd7);
    check("lat_t2_data", wb_data, 32'hFFFF_FF80);
    tick();
    check("busy7_clear", reg_busy, 32'd0);

    // Table of single-beat formatting vectors.
    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].rg);
      if (vecs[i].src == 1'b0) begin
        cpu_dcache_rvalid = 1'b1;
        cpu_dcache_rtag   = {vecs[i].code, vecs[i].rg};
        cpu_dcache_rdata  = vecs[i].data;
      end else begin
        div_valid    = 1'b1;
        div_dest_reg = vecs[i].rg;
        div_result   = vecs[i].data;
      end
      sb.push_back('{vecs[i].rg, vecs[i].exp});
      tick();
      cpu_dcache_rvalid = 1'b0;
      div_valid = 1'b0;
      repeat (3) tick();
    end
    check("table_drained", sb.size(), 32'd0);
    check("table_busy", reg_busy, 32'd0);
    check("table_err", 32'(error_flags), 32'(ERR_AFTER_TABLE));

    // Simultaneous beats: dcache wins first tie, divider wins the next.
    for (int rep = 0; rep < 2; rep++) begin
      issue(5'd3);
      issue(5'd4);
      cpu_dcache_rvalid = 1'b1; cpu_dcache_rtag = {4'b1000, 5'd3}; cpu_dcache_rdata = 32'hA000_0003 + rep;
      div_valid = 1'b1; div_dest_reg = 5'd4; div_result = 32'hD000_0004 + rep;
      if (rep == 0) begin
        sb.push_back('{5'd3, 32'hA000_0003});
        sb.push_back('{5'd4, 32'hD000_0004});
      end else begin
        sb.push_back('{5'd4, 32'hD000_0005});
        sb.push_back('{5'd3, 32'hA000_0004});
      end
      tick();
      cpu_dcache_rvalid = 1'b0; div_valid = 1'b0;
      tick();
      check("tie_first_valid", 32'(wb_valid), 32'd1);
      check("tie_first_reg", 32'(wb_dest_reg), (rep == 0) ? 32'd3 : 32'd4);
      tick();
      check("tie_second_valid", 32'(wb_valid), 32'd1);
      check("tie_second_reg", 32'(wb_dest_reg), (rep == 0) ? 32'd4 : 32'd3);
      repeat (2) tick();
    end
    check("tie_drained", sb.size(), 32'd0);

    // Backpressure: five returns while the CPU stalls, three accepted.
    issue(5'd20); issue(5'd21); issue(5'd22);
    cpu_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cpu_dcache_rvalid = 1'b1;
      cpu_dcache_rtag   = {4'b1000, 5'(20 + k)};
      cpu_dcache_rdata  = 32'hB000_0000 + 32'(k);
      check("bp_rready", 32'(cpu_dcache_rready), (k < 3) ? 32'd1 : 32'd0);
      if (k < 3) sb.push_back('{5'(20 + k), 32'hB000_0000 + 32'(k)});
      if (k >= 2) begin
        check("bp_hold_valid", 32'(wb_valid), 32'd1);
        check("bp_hold_reg", 32'(wb_dest_reg), 32'd20);
      end
      tick();
    end
    cpu_dcache_rvalid = 1'b0;
    check("bp_hold_data", wb_data, 32'hB000_0000);
    tick();
    cpu_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check("bp_drain_valid", 32'(wb_valid), 32'd1);
      check("bp_drain_reg", 32'(wb_dest_reg), 32'(20 + j));
      tick();
    end
    check("bp_idle", 32'(wb_valid), 32'd0);
    check("bp_drained", sb.size(), 32'd0);
    check("bp_busy", reg_busy, 32'd0);

    // Issue to reg 9 coincident with its consumed writeback: set wins.
    issue(5'd9);
    cpu_dcache_rvalid = 1'b1; cpu_dcache_rtag = {4'b1000, 5'd9}; cpu_dcache_rdata = 32'h0000_0099;
    sb.push_back('{5'd9, 32'h0000_0099});
    tick();
    cpu_dcache_rvalid = 1'b0;
    tick();
    check("sb9_wb_valid", 32'(wb_valid), 32'd1);
    issue_valid = 1'b1; issue_reg = 5'd9;
    tick();
    issue_valid = 1'b0; issue_reg = 5'd0;
    check("sb9_set_wins", reg_busy, 32'h0000_0200);
    issue(5'd9);
    check("sb9_dup_busy", reg_busy, 32'h0000_0200);
    check("sb9_dup_err", 32'(error_flags), 32'(ERR_AFTER_DUP));

    // Divider beat to r0 is swallowed.
    check("r0_ready_before", 32'(div_ready), 32'd1);
    div_valid = 1'b1; div_dest_reg = 5'd0; div_result = 32'h0000_1234;
    tick();
    div_valid = 1'b0;
    check("r0_ready_after", 32'(div_ready), 32'd1);
    for (int j = 0; j < 3; j++) begin
      check("r0_no_wb", 32'(wb_valid), 32'd0);
      tick();
    end
    check("r0_busy", reg_busy, 32'h0000_0200);

    // Reset with both queues full and a beat held in the slot.
    for (int r = 25; r <= 30; r++) issue(5'(r));
    cpu_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cpu_dcache_rvalid = 1'b1; cpu_dcache_rtag = {4'b1000, 5'(25 + k)}; cpu_dcache_rdata = 32'hC000_0000 + 32'(k);
      div_valid = 1'b1; div_dest_reg = 5'(28 + k); div_result = 32'hE000_0000 + 32'(k);
      tick();
    end
    cpu_dcache_rvalid = 1'b0; div_valid = 1'b0;
    check("pre_rst_valid", 32'(wb_valid), 32'd1);
    check("pre_rst_rready", 32'(cpu_dcache_rready), 32'd0);
    check("pre_rst_div_ready", 32'(div_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(wb_valid), 32'd0);
    check("mid_rst_busy", reg_busy, 32'd0);
    check("mid_rst_rready", 32'(cpu_dcache_rready), 32'd1);
    check("mid_rst_div_ready", 32'(div_ready), 32'd1);
    check("mid_rst_err", 32'(error_flags), 32'd0);
    cpu_ready = 1'b1;

    // Post-reset beat must come out alone: no stale entries survive.
    issue(5'd5);
    cpu_dcache_rvalid = 1'b1; cpu_dcache_rtag = {4'b1000, 5'd5}; cpu_dcache_rdata = 32'h0000_0055;
    sb.push_back('{5'd5, 32'h0000_0055});
    tick();
    cpu_dcache_rvalid = 1'b0;
    repeat (4) tick();
    check("post_rst_drained", sb.size(), 32'd0);
    check("post_rst_idle", 32'(wb_valid), 32'd0);
    check("post_rst_busy", reg_busy, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_wb_arbiter.md
Name: cpu_wb_arbiter

Overview:
Writeback scheduler for the CPU's long-latency results. It buffers load returns from the dcache and results from the divider in per-source queues. It formats load data (byte/half/word extraction with sign extension), then grants the single CPU writeback port between the two sources round-robin. It also keeps a per-register pending scoreboard so the issue stage can detect RAW/WAW hazards against outstanding results.

Parameters:
Q_DEPTH, 2, entries per source queue (power of two, 2..8)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
cpu_dcache_rvalid  in  1  load return valid
cpu_dcache_rready  out  1  queue can accept load return
cpu_dcache_rdata  in  32  raw word from dcache
cpu_dcache_rtag  in  9  [8:5] size/offset code, [4:0] dest reg
div_valid  in  1  divider result valid
div_ready  out  1  queue can accept divider result
div_result  in  32  divider result
div_dest_reg  in  5  divider dest reg
issue_valid  in  1  long-latency op issued this cycle
issue_reg  in  5  its dest reg
reg_busy  out  32  bit n set = result pending for reg n
wb_valid  out  1  writeback beat valid
wb_dest_reg  out  5  writeback dest reg
wb_data  out  32  writeback data
cpu_ready  in  1  CPU consumes wb beat this cycle
error_flags  out  3  sticky [0] bad rtag code, [1] duplicate issue, [2] writeback to non-pending reg

Behaviour:
- Reset values: wb_valid=0, wb_dest_reg=0, wb_data=0, reg_busy=0, error_flags=0, both queues empty, rr_last=DIV so dcache wins the first tie.
- Source handshake: a beat transfers when valid&ready. cpu_dcache_rready and div_ready are 1 exactly when the respective queue is not full (registered count < Q_DEPTH). They depend only on registered state and never combinationally on valid.
- A beat whose dest reg is 0 is accepted and discarded, with no queue write.
- Load formatting on entry, by rtag[8:5]:
  - 0000..0011: byte 0..3, sign-extended.
  - 0100: half at [15:0], sign-extended.
  - 0110: half at [31:16], sign-extended.
  - 1000: full word.
  - Any other code: data=0 and error_flags[0] set.
- Output stage: a single registered slot. The slot is "free" when !wb_valid or cpu_ready.
  - If free and at least one queue is non-empty: load the winner's head, pop it, set wb_valid=1.
  - If free and both queues are empty: wb_valid=0.
  - If not free: hold all wb_* stable.
- Arbitration: if only one queue head is valid, grant it. If both are valid, grant the source that is not rr_last, then set rr_last to the granted source.
- Latency: a beat transferred in cycle t, into empty queues with a free slot, is on wb_* in cycle t+2.
- Throughput: one writeback per cycle while cpu_ready=1. Simultaneous dcache and divider beats are both accepted if neither queue is full.
- Scoreboard:
  - issue_valid with issue_reg!=0 sets reg_busy[issue_reg] at the clock edge.
  - A consumed writeback (wb_valid&cpu_ready) clears reg_busy[wb_dest_reg].
  - Same reg set and cleared in the same cycle: set wins.
  - issue to r0: ignored.
  - issue to a reg already busy: bit stays set, error_flags[1] set. The issue stage must stall on reg_busy; this case is illegal.
  - Consumed writeback to a reg whose bit is clear: error_flags[2] set.
- Queues are circular with wrap-around pointers. Simultaneous push and pop on a full queue is not allowed: ready is already 0 when full.
- Reset asserted mid-operation: all queue contents and in-flight wb beats are dropped and the reset values above apply in the next cycle. The owner of the reset must also reset the sources.

Optional Feature:
WB_ARB_ERR_CHECK_EN
- Defined:
  - error_flags is driven as described above, with sticky bits cleared only by reset.
  - Each first assertion of a bit prints "ERROR %t: cpu_wb_arbiter <cause>" via $display.
  - error_flags[0] is also set if either queue is pushed while full (a source protocol violation).
- Undefined: error_flags is tied to 0, there are no $display statements, and the check logic is not synthesised. Functional behaviour is otherwise identical.

Test Plan:
1. Load return rtag={4'b0011,5'd7}, rdata=32'h80FF_0000, cpu_ready=1 → two cycles later wb_dest_reg=7, wb_data=32'hFFFF_FF80; reg_busy[7] (set by an earlier issue) clears.
2. Dcache beat (reg 3) and divider beat (reg 4) in the same cycle, after reset → wb gives reg 3 then reg 4 on consecutive cycles. Repeat → the order alternates: reg 4 first on the next tie.
3. cpu_ready=0 for 6 cycles while 5 dcache returns arrive (Q_DEPTH=2) → cpu_dcache_rready drops after the queue fills, wb_* stays stable; release → all 3 accepted beats drain in order, with no loss.
4. issue_valid, issue_reg=9 in the same cycle as a consumed writeback to reg 9 → reg_busy[9]=1 afterwards. Second issue to reg 9 with the macro defined → error_flags[1]=1.
5. Divider beat with div_dest_reg=0 → div_ready stays 1, no wb_valid pulse, reg_busy unchanged.
6. Reset asserted while both queues hold 2 entries and wb_valid=1 → next cycle wb_valid=0, reg_busy=0, both readies=1, error_flags=0.
